// File: rtl/mpu_bus_master.sv
// Microprocessor-style parallel bus master: one command at a time is turned into
// a SETUP / STROBE / HOLD cycle on an active-low enable/strobe bus.
module mpu_bus_master #(
   parameter int unsigned SETUP_CYCLES  = 1,
   parameter int unsigned STROBE_CYCLES = 2,
   parameter int unsigned HOLD_CYCLES   = 1
) (
   input  logic        clk,
   input  logic        _reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [1:0]  cmd_be,
   input  logic [15:0] cmd_addr,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_data,
   output logic        busy,
   output logic        _mpu_en,
   output logic        _mpu_rd,
   output logic        _mpu_wr,
   output logic [1:0]  _mpu_be,
   output logic [15:0] mpu_addr,
   output logic [15:0] mpu_data_out,
   input  logic [15:0] mpu_data_in
);

   // Phase counter is loaded with N-1 and counts down to zero within each phase.
   localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
   localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
   localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   state_t     state;
   logic [3:0] phase_cnt;
   logic       is_write;

   assign cmd_ready = (state == IDLE) & _reset;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         state        <= IDLE;
         phase_cnt    <= '0;
         is_write     <= 1'b0;
         _mpu_en      <= 1'b1;
         _mpu_rd      <= 1'b1;
         _mpu_wr      <= 1'b1;
         _mpu_be      <= 2'b11;
         mpu_addr     <= '0;
         mpu_data_out <= '0;
         rsp_valid    <= 1'b0;
         rsp_data     <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  state        <= SETUP;
                  phase_cnt    <= SETUP_LOAD;
                  is_write     <= cmd_write;
                  _mpu_en      <= 1'b0;
                  _mpu_be      <= ~cmd_be;
                  mpu_addr     <= cmd_addr;
                  mpu_data_out <= cmd_write ? cmd_wdata : 16'h0000;
               end
            end
            SETUP: begin
               if (phase_cnt == '0) begin
                  state     <= STROBE;
                  phase_cnt <= STROBE_LOAD;
                  if (is_write) _mpu_wr <= 1'b0;
                  else          _mpu_rd <= 1'b0;
               end else begin
                  phase_cnt <= phase_cnt - 4'd1;
               end
            end
            STROBE: begin
               if (phase_cnt == '0) begin
                  state     <= HOLD;
                  phase_cnt <= HOLD_LOAD;
                  _mpu_rd   <= 1'b1;
                  _mpu_wr   <= 1'b1;
                  // Read data is taken on the edge that releases the strobe.
                  if (!is_write) begin
                     rsp_data  <= mpu_data_in;
                     rsp_valid <= 1'b1;
                  end
               end else begin
                  phase_cnt <= phase_cnt - 4'd1;
               end
            end
            HOLD: begin
               if (phase_cnt == '0) begin
                  state        <= IDLE;
                  phase_cnt    <= '0;
                  _mpu_en      <= 1'b1;
                  _mpu_be      <= 2'b11;
                  mpu_data_out <= '0;
               end else begin
                  phase_cnt <= phase_cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mpu_bus_master.sv
// Directed bench for mpu_bus_master: default-timing instance (a) and a 3/4/2 instance (b)
// sharing command inputs.
module tb_mpu_bus_master;

   logic        clk         = 1'b0;
   logic        _reset      = 1'b1;
   logic        cmd_valid   = 1'b0;
   logic        cmd_write   = 1'b0;
   logic [1:0]  cmd_be      = 2'b00;
   logic [15:0] cmd_addr    = 16'h0000;
   logic [15:0] cmd_wdata   = 16'h0000;
   logic [15:0] mpu_data_in = 16'h1111;

   logic        a_cmd_ready, a_rsp_valid, a_busy, a_en, a_rd, a_wr;
   logic [1:0]  a_be;
   logic [15:0] a_rsp_data, a_addr, a_dout;
   logic        b_cmd_ready, b_rsp_valid, b_busy, b_en, b_rd, b_wr;
   logic [1:0]  b_be;
   logic [15:0] b_rsp_data, b_addr, b_dout;

   logic [7:0]  ctrl_a, ctrl_b;
   int          checks = 0;
   int          passed = 0;

   always #5 clk = ~clk;

   mpu_bus_master u_a (
      .clk(clk), ._reset(_reset), .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready),
      .cmd_write(cmd_write), .cmd_be(cmd_be), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .busy(a_busy),
      ._mpu_en(a_en), ._mpu_rd(a_rd), ._mpu_wr(a_wr), ._mpu_be(a_be),
      .mpu_addr(a_addr), .mpu_data_out(a_dout), .mpu_data_in(mpu_data_in)
   );

   mpu_bus_master #(.SETUP_CYCLES(3), .STROBE_CYCLES(4), .HOLD_CYCLES(2)) u_b (
      .clk(clk), ._reset(_reset), .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready),
      .cmd_write(cmd_write), .cmd_be(cmd_be), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .busy(b_busy),
      ._mpu_en(b_en), ._mpu_rd(b_rd), ._mpu_wr(b_wr), ._mpu_be(b_be),
      .mpu_addr(b_addr), .mpu_data_out(b_dout), .mpu_data_in(mpu_data_in)
   );

   // {en, rd, wr, be[1:0], cmd_ready, busy, rsp_valid}
   assign ctrl_a = {a_en, a_rd, a_wr, a_be, a_cmd_ready, a_busy, a_rsp_valid};
   assign ctrl_b = {b_en, b_rd, b_wr, b_be, b_cmd_ready, b_busy, b_rsp_valid};

   task automatic issue(input logic wr, input logic [1:0] be, input logic [15:0] addr,
                        input logic [15:0] wd);
      @(negedge clk);
      cmd_write = wr;
      cmd_be    = be;
      cmd_addr  = addr;
      cmd_wdata = wd;
      cmd_valid = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      #2 _reset = 1'b0;
      #20;
      checks++; if (ctrl_a !== 8'b11111000) $display("FAIL rst_ctrl_a got %b exp %b", ctrl_a, 8'b11111000); else passed++;
      checks++; if (ctrl_b !== 8'b11111000) $display("FAIL rst_ctrl_b got %b exp %b", ctrl_b, 8'b11111000); else passed++;
      checks++; if ({a_addr, a_dout} !== 32'h0) $display("FAIL rst_bus got %h exp %h", {a_addr, a_dout}, 32'h0); else passed++;
      checks++; if (a_rsp_data !== 16'h0) $display("FAIL rst_rdata got %h exp 0000", a_rsp_data); else passed++;
      @(negedge clk);
      _reset = 1'b1;
      #1;
      checks++; if (ctrl_a !== 8'b11111100) $display("FAIL rst_rel_ctrl got %b exp %b", ctrl_a, 8'b11111100); else passed++;
   endtask

   task automatic test_read();
      logic [7:0]  ec;
      logic [15:0] ed;
      issue(1'b0, 2'b11, 16'h0F00, 16'hFFFF);
      checks++; if (a_cmd_ready !== 1'b1) $display("FAIL rd_ready got %b exp 1", a_cmd_ready); else passed++;
      @(posedge clk); #1 cmd_valid = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         ec = {k > 4, !(k == 2 || k == 3), 1'b1, (k <= 4) ? 2'b00 : 2'b11, k == 5, k <= 4, k == 4};
         ed = (k >= 4) ? 16'hA55A : 16'h0000;
         checks++; if (ctrl_a !== ec) $display("FAIL rd_ctrl c%0d got %b exp %b", k, ctrl_a, ec); else passed++;
         checks++; if ({a_addr, a_dout} !== {16'h0F00, 16'h0000}) $display("FAIL rd_bus c%0d got %h exp %h", k, {a_addr, a_dout}, {16'h0F00, 16'h0000}); else passed++;
         checks++; if (a_rsp_data !== ed) $display("FAIL rd_rdata c%0d got %h exp %h", k, a_rsp_data, ed); else passed++;
         if (k == 3) mpu_data_in = 16'hA55A;
         if (k == 4) mpu_data_in = 16'hDEAD;
      end
   endtask

   task automatic test_write(input logic [1:0] be, input logic [15:0] addr, input logic [15:0] wd);
      logic [7:0]  ec;
      logic [15:0] ed;
      issue(1'b1, be, addr, wd);
      checks++; if (a_cmd_ready !== 1'b1) $display("FAIL wr_ready got %b exp 1", a_cmd_ready); else passed++;
      @(posedge clk); #1 cmd_valid = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         ec = {k > 4, 1'b1, !(k == 2 || k == 3), (k <= 4) ? ~be : 2'b11, k == 5, k <= 4, 1'b0};
         ed = (k <= 4) ? wd : 16'h0000;
         checks++; if (ctrl_a !== ec) $display("FAIL wr_ctrl c%0d got %b exp %b", k, ctrl_a, ec); else passed++;
         checks++; if ({a_addr, a_dout} !== {addr, ed}) $display("FAIL wr_bus c%0d got %h exp %h", k, {a_addr, a_dout}, {addr, ed}); else passed++;
         checks++; if (a_rsp_data !== 16'hA55A) $display("FAIL wr_rdata_keep c%0d got %h exp a55a", k, a_rsp_data); else passed++;
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  ec;
      logic [15:0] ea, ed, er;
      logic        t1, t2;
      issue(1'b1, 2'b11, 16'h1111, 16'h2222);
      @(posedge clk); #1;
      cmd_write   = 1'b0;
      cmd_be      = 2'b10;
      cmd_addr    = 16'h3333;
      cmd_wdata   = 16'h4444;
      mpu_data_in = 16'h5A5A;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         t1 = (k <= 4);
         t2 = (k >= 6 && k <= 9);
         ec = {!(t1 || t2), !(k == 7 || k == 8), !(k == 2 || k == 3),
               t1 ? 2'b00 : (t2 ? 2'b01 : 2'b11), k == 5 || k == 10, t1 || t2, k == 9};
         ea = (k <= 5) ? 16'h1111 : 16'h3333;
         ed = t1 ? 16'h2222 : 16'h0000;
         er = (k >= 9) ? 16'h5A5A : 16'hA55A;
         checks++; if (ctrl_a !== ec) $display("FAIL b2b_ctrl c%0d got %b exp %b", k, ctrl_a, ec); else passed++;
         checks++; if ({a_addr, a_dout} !== {ea, ed}) $display("FAIL b2b_bus c%0d got %h exp %h", k, {a_addr, a_dout}, {ea, ed}); else passed++;
         checks++; if (a_rsp_data !== er) $display("FAIL b2b_rdata c%0d got %h exp %h", k, a_rsp_data, er); else passed++;
         if (k == 6) cmd_valid = 1'b0;
      end
   endtask

   task automatic test_busy_ignore();
      logic [7:0]  ec;
      logic [15:0] ed;
      issue(1'b1, 2'b11, 16'hABCD, 16'h0123);
      @(posedge clk); #1 cmd_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         ec = {k > 4, 1'b1, !(k == 2 || k == 3), (k <= 4) ? 2'b00 : 2'b11, k >= 5, k <= 4, 1'b0};
         ed = (k <= 4) ? 16'h0123 : 16'h0000;
         checks++; if (ctrl_a !== ec) $display("FAIL busy_ctrl c%0d got %b exp %b", k, ctrl_a, ec); else passed++;
         checks++; if ({a_addr, a_dout} !== {16'hABCD, ed}) $display("FAIL busy_bus c%0d got %h exp %h", k, {a_addr, a_dout}, {16'hABCD, ed}); else passed++;
         case (k)
            1: begin cmd_valid = 1'b1; cmd_write = 1'b0; cmd_be = 2'b00; cmd_addr = 16'hFFFF; cmd_wdata = 16'h5555; end
            2: begin cmd_valid = 1'b0; cmd_addr = 16'h0000; end
            3: begin cmd_valid = 1'b1; cmd_write = 1'b1; cmd_be = 2'b01; cmd_addr = 16'h1357; cmd_wdata = 16'h2468; end
            4: begin cmd_addr = 16'h7777; cmd_wdata = 16'h8888; end
            5: cmd_valid = 1'b0;
            default: ;
         endcase
      end
   endtask

   task automatic test_params();
      logic [7:0]  ec;
      logic [15:0] ed;
      cmd_valid = 1'b0;
      repeat (12) @(negedge clk);
      issue(1'b1, 2'b10, 16'h4242, 16'h9999);
      checks++; if (b_cmd_ready !== 1'b1) $display("FAIL par_ready got %b exp 1", b_cmd_ready); else passed++;
      @(posedge clk); #1 cmd_valid = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         ec = {k > 9, 1'b1, !(k >= 4 && k <= 7), (k <= 9) ? 2'b01 : 2'b11, k >= 10, k <= 9, 1'b0};
         ed = (k <= 9) ? 16'h9999 : 16'h0000;
         checks++; if (ctrl_b !== ec) $display("FAIL par_ctrl c%0d got %b exp %b", k, ctrl_b, ec); else passed++;
         checks++; if ({b_addr, b_dout} !== {16'h4242, ed}) $display("FAIL par_bus c%0d got %h exp %h", k, {b_addr, b_dout}, {16'h4242, ed}); else passed++;
      end
   endtask

   task automatic test_reset_abort();
      logic [7:0]  ec;
      logic [15:0] er;
      mpu_data_in = 16'hCAFE;
      issue(1'b0, 2'b11, 16'h0BAD, 16'h0000);
      @(posedge clk); #1 cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (a_rd !== 1'b0) $display("FAIL abort_in_strobe got %b exp 0", a_rd); else passed++;
      #2 _reset = 1'b0;
      #1;
      checks++; if (ctrl_a !== 8'b11111000) $display("FAIL abort_ctrl_a got %b exp %b", ctrl_a, 8'b11111000); else passed++;
      checks++; if (ctrl_b !== 8'b11111000) $display("FAIL abort_ctrl_b got %b exp %b", ctrl_b, 8'b11111000); else passed++;
      checks++; if ({a_addr, a_dout} !== 32'h0) $display("FAIL abort_bus got %h exp %h", {a_addr, a_dout}, 32'h0); else passed++;
      checks++; if (a_rsp_data !== 16'h0) $display("FAIL abort_rdata got %h exp 0000", a_rsp_data); else passed++;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++; if (ctrl_a !== 8'b11111000) $display("FAIL abort_hold_ctrl t%0d got %b exp %b", k, ctrl_a, 8'b11111000); else passed++;
      end
      _reset      = 1'b1;
      cmd_write   = 1'b0;
      cmd_be      = 2'b11;
      cmd_addr    = 16'h0042;
      cmd_wdata   = 16'h0000;
      mpu_data_in = 16'h600D;
      cmd_valid   = 1'b1;
      #1;
      checks++; if (a_cmd_ready !== 1'b1) $display("FAIL abort_rel_ready got %b exp 1", a_cmd_ready); else passed++;
      @(posedge clk); #1 cmd_valid = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         ec = {k > 4, !(k == 2 || k == 3), 1'b1, (k <= 4) ? 2'b00 : 2'b11, k == 5, k <= 4, k == 4};
         er = (k >= 4) ? 16'h600D : 16'h0000;
         checks++; if (ctrl_a !== ec) $display("FAIL post_ctrl c%0d got %b exp %b", k, ctrl_a, ec); else passed++;
         checks++; if ({a_addr, a_dout} !== {16'h0042, 16'h0000}) $display("FAIL post_bus c%0d got %h exp %h", k, {a_addr, a_dout}, {16'h0042, 16'h0000}); else passed++;
         checks++; if (a_rsp_data !== er) $display("FAIL post_rdata c%0d got %h exp %h", k, a_rsp_data, er); else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write(2'b11, 16'h1234, 16'hBEEF);
      test_write(2'b00, 16'h00C3, 16'h7E7E);
      test_back_to_back();
      test_busy_ignore();
      test_params();
      test_reset_abort();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/mpu_bus_master.md
MPU_BUS_MASTER -- requirements
Module: mpu_bus_master

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 1, meaning cycles of address/enable setup before strobe; legal range 1..15.
REQ-002 SHALL have parameter STROBE_CYCLES, default 2, meaning cycles the read or write strobe is held low; legal range 1..15.
REQ-003 SHALL have parameter HOLD_CYCLES, default 1, meaning cycles of address/enable hold after strobe release; legal range 1..15.
REQ-004 SHALL have ports: clk  in  1  system clock; _reset  in  1  reset (active low).
REQ-005 SHALL be built on one clock; reset is asynchronous and active-low.
REQ-006 SHALL have ports: cmd_valid  in  1  command offered; cmd_ready  out  1  command accepted this cycle when both high; cmd_write  in  1  1=write, 0=read.
REQ-007 SHALL have ports: cmd_be  in  2  byte enables (active high); cmd_addr  in  16  target address; cmd_wdata  in  16  write data.
REQ-008 SHALL have ports: rsp_valid  out  1  read-data pulse; rsp_data  out  16  captured read data; busy  out  1  transaction in progress.
REQ-009 SHALL have ports: _mpu_en  out  1  enable (active low); _mpu_rd  out  1  read strobe (active low); _mpu_wr  out  1  write strobe (active low).
REQ-010 SHALL have ports: _mpu_be  out  2  byte enable (active low); mpu_addr  out  16  address bus; mpu_data_out  out  16  write data bus; mpu_data_in  in  16  read data bus.

Function
REQ-011 SHALL implement states IDLE, SETUP, STROBE, HOLD with a 4-bit phase counter.
REQ-012 SHALL drive cmd_ready = 1 only in IDLE with _reset high; busy = 1 in SETUP, STROBE, HOLD.
REQ-013 SHALL, on clk edge with cmd_valid & cmd_ready, register cmd_addr, ~cmd_be, cmd_write and cmd_wdata (or 16'h0000 for reads) onto bus outputs and enter SETUP.
REQ-014 SHALL hold _mpu_en low in SETUP, STROBE, HOLD; high in IDLE.
REQ-015 SHALL remain in SETUP exactly SETUP_CYCLES cycles, then STROBE exactly STROBE_CYCLES cycles, then HOLD exactly HOLD_CYCLES cycles, then IDLE.
REQ-016 SHALL drive _mpu_wr low (write) or _mpu_rd low (read) only in STROBE; never both low.
REQ-017 SHALL keep mpu_addr, _mpu_be, mpu_data_out stable from SETUP entry through final HOLD cycle.
REQ-018 SHALL, on reads, sample mpu_data_in at the clk edge ending the last STROBE cycle into rsp_data and pulse rsp_valid for exactly the first HOLD cycle.
REQ-019 SHALL not pulse rsp_valid for writes; rsp_data SHALL retain its last value until the next read capture.
REQ-020 SHALL, on return to IDLE, set _mpu_be to 2'b11 and mpu_data_out to 0; mpu_addr SHALL retain its last value.
REQ-021 SHALL guarantee at least one IDLE cycle (_mpu_en high) between back-to-back transactions; total occupancy per command = SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES+1 cycles.
REQ-022 SHALL perform a full bus cycle even when cmd_be = 2'b00 (_mpu_be = 2'b11 throughout).
REQ-023 SHALL ignore cmd_valid and all command fields while busy.

Reset
REQ-024 SHALL, while _reset low, asynchronously force IDLE, counter 0, _mpu_en/_mpu_rd/_mpu_wr = 1, _mpu_be = 2'b11, mpu_addr = 0, mpu_data_out = 0, rsp_valid = 0, rsp_data = 0, cmd_ready = 0.
REQ-025 SHALL abort any transaction in progress when _reset asserts, without emitting rsp_valid; first command accepted on the first clk edge after _reset deasserts with cmd_valid high.

Verification
REQ-026 Write addr 16'h1234, data 16'hBEEF, be 2'b11, defaults -> _mpu_en low cycles 1-4, _mpu_wr low cycles 2-3, _mpu_be 2'b00, mpu_data_out 16'hBEEF, no rsp_valid, cmd_ready high again cycle 5.
REQ-027 Read addr 16'h0F00, device returns 16'hA55A -> _mpu_rd low 2 cycles, rsp_valid single pulse in HOLD, rsp_data 16'hA55A, mpu_data_out 0 throughout.
REQ-028 cmd_valid held high with two queued commands -> exactly one IDLE cycle with _mpu_en high between transactions, second command fields unchanged on bus.
REQ-029 Parameters 3/4/2, byte write be 2'b10 -> _mpu_be 2'b01, strobe low exactly 4 cycles after 3 setup cycles, 2 hold cycles.
REQ-030 _reset asserted mid-STROBE of a read -> all strobes high and _mpu_en high immediately (asynchronous), rsp_valid never pulses, next command after release completes normally.
REQ-031 cmd_valid toggled with changing fields while busy -> bus values unchanged, cmd_ready low, no extra transaction.
